// File: rtl/flag_branch_unit.sv
// Flag register with EX-stage bypass, branch condition evaluation and a
// one-cycle fetch-redirect FSM with a saturating taken-branch counter.
module flag_branch_unit #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ex_valid,
    input  logic [3:0]       ex_opcode,
    input  logic             alu_z,
    input  logic             alu_n,
    input  logic             alu_v,
    input  logic             stall,
    input  logic             id_branch,
    input  logic             id_is_br,
    input  logic [2:0]       id_ccc,
    input  logic [8:0]       id_imm9,
    input  logic [15:0]      id_pc_plus2,
    input  logic [15:0]      id_rs_val,
    output logic             flag_z,
    output logic             flag_n,
    output logic             flag_v,
    output logic             redirect_valid,
    output logic [15:0]      redirect_pc,
    output logic [CNT_W-1:0] taken_cnt
);

    typedef enum logic {IDLE, REDIRECT} state_t;

    state_t      state, state_next;
    logic        wr_all, wr_z;
    logic        eff_z, eff_n, eff_v;
    logic        cond, take;
    logic [15:0] target;

    always_comb begin
        wr_all = 1'b0;
        wr_z   = 1'b0;
        if (ex_valid && !stall) begin
            case (ex_opcode)
                4'b0000, 4'b0001:                     begin wr_all = 1'b1; wr_z = 1'b1; end
                4'b0010, 4'b0100, 4'b0101, 4'b0110:   wr_z = 1'b1;
                default: ;
            endcase
        end
    end

    // Branch in ID sees the flags the EX instruction is writing this cycle.
    assign eff_z = wr_z   ? alu_z : flag_z;
    assign eff_n = wr_all ? alu_n : flag_n;
    assign eff_v = wr_all ? alu_v : flag_v;

    always_comb begin
        cond = 1'b0;
        case (id_ccc)
            3'b000: cond = !eff_z;
            3'b001: cond = eff_z;
            3'b010: cond = !eff_z && !eff_n;
            3'b011: cond = eff_n;
            3'b100: cond = eff_z || !eff_n;
            3'b101: cond = eff_n || eff_z;
            3'b110: cond = eff_v;
            3'b111: cond = 1'b1;
            default: cond = 1'b0;
        endcase
    end

    assign target = id_is_br ? id_rs_val
                             : id_pc_plus2 + {{6{id_imm9[8]}}, id_imm9, 1'b0};

    always_comb begin
        state_next = state;
        take       = 1'b0;
        case (state)
            IDLE: begin
                if (id_branch && !stall && cond) begin
                    take       = 1'b1;
                    state_next = REDIRECT;
                end
            end
            REDIRECT: state_next = IDLE;
            default:  state_next = IDLE;
        endcase
    end

    assign redirect_valid = (state == REDIRECT);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            flag_z      <= 1'b0;
            flag_n      <= 1'b0;
            flag_v      <= 1'b0;
            redirect_pc <= '0;
            taken_cnt   <= '0;
        end else begin
            if (wr_z) begin
                flag_z <= alu_z;
            end
            if (wr_all) begin
                flag_n <= alu_n;
                flag_v <= alu_v;
            end
            if (take) begin
                redirect_pc <= target;
                if (taken_cnt != '1) begin
                    taken_cnt <= taken_cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_flag_branch_unit.sv
// Directed-vector bench for flag_branch_unit: per-cycle table plus stall,
// saturation and reset-during-redirect sequences.
module tb_flag_branch_unit;

    localparam int unsigned CW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          ex_valid;
    logic [3:0]    ex_opcode;
    logic          alu_z, alu_n, alu_v;
    logic          stall;
    logic          id_branch, id_is_br;
    logic [2:0]    id_ccc;
    logic [8:0]    id_imm9;
    logic [15:0]   id_pc_plus2, id_rs_val;
    logic          flag_z, flag_n, flag_v;
    logic          redirect_valid;
    logic [15:0]   redirect_pc;
    logic [CW-1:0] taken_cnt;

    int checks = 0;
    int errors = 0;

    flag_branch_unit #(.CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_opcode(ex_opcode),
        .alu_z(alu_z), .alu_n(alu_n), .alu_v(alu_v), .stall(stall),
        .id_branch(id_branch), .id_is_br(id_is_br), .id_ccc(id_ccc),
        .id_imm9(id_imm9), .id_pc_plus2(id_pc_plus2), .id_rs_val(id_rs_val),
        .flag_z(flag_z), .flag_n(flag_n), .flag_v(flag_v),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .taken_cnt(taken_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          ev;
        logic [3:0]    op;
        logic          az, an, av, st, br, isbr;
        logic [2:0]    ccc;
        logic [8:0]    imm;
        logic [15:0]   pc, rs;
        logic          fz, fn, fv, rv;
        logic [15:0]   rpc;
        logic [CW-1:0] cnt;
    } vec_t;

    vec_t vecs[25];

    // Packed view: {flag_z, flag_n, flag_v, redirect_valid, redirect_pc, taken_cnt}
    function automatic logic [23:0] pack_out(logic z, logic n, logic v, logic rv,
                                             logic [15:0] pc, logic [CW-1:0] cnt);
        return {z, n, v, rv, pc, cnt};
    endfunction

    task automatic check(input string nm, input logic [23:0] act, input logic [23:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got z n v rv pc cnt = %b %b %b %b %h %0d, want %b %b %b %b %h %0d",
                     nm, act[23], act[22], act[21], act[20], act[19:4], act[3:0],
                     exp[23], exp[22], exp[21], exp[20], exp[19:4], exp[3:0]);
        end
    endtask

    task automatic check_out(input string nm, input logic z, input logic n, input logic v,
                             input logic rv, input logic [15:0] pc, input logic [CW-1:0] cnt);
        check(nm, pack_out(flag_z, flag_n, flag_v, redirect_valid, redirect_pc, taken_cnt),
              pack_out(z, n, v, rv, pc, cnt));
    endtask

    task automatic idle_inputs();
        ex_valid = 1'b0; ex_opcode = 4'h0; alu_z = 1'b0; alu_n = 1'b0; alu_v = 1'b0;
        stall = 1'b0; id_branch = 1'b0; id_is_br = 1'b0; id_ccc = 3'd0;
        id_imm9 = 9'h000; id_pc_plus2 = 16'h0000; id_rs_val = 16'h0000;
    endtask

    task automatic br_reg(input logic [2:0] ccc, input logic [15:0] rs, input logic st);
        idle_inputs();
        id_branch = 1'b1; id_is_br = 1'b1; id_ccc = ccc; id_rs_val = rs; stall = st;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [CW-1:0] cnt_exp;

    initial begin
        //        ev op     az an av st br isbr ccc imm     pc        rs         fz fn fv rv rpc       cnt
        vecs[0]  = '{1, 4'h1, 1, 0, 0, 0, 0, 0, 3'd0, 9'h000, 16'h0000, 16'h0000, 1, 0, 0, 0, 16'h0000, 4'd0};
        vecs[1]  = '{1, 4'h2, 0, 1, 1, 0, 0, 0, 3'd0, 9'h000, 16'h0000, 16'h0000, 0, 0, 0, 0, 16'h0000, 4'd0};
        vecs[2]  = '{1, 4'h8, 1, 1, 1, 0, 0, 0, 3'd0, 9'h000, 16'h0000, 16'h0000, 0, 0, 0, 0, 16'h0000, 4'd0};
        vecs[3]  = '{1, 4'h0, 0, 1, 0, 0, 1, 0, 3'd3, 9'h004, 16'h0100, 16'h0000, 0, 1, 0, 1, 16'h0108, 4'd1};
        vecs[4]  = '{0, 4'h0, 0, 0, 0, 0, 0, 0, 3'd0, 9'h000, 16'h0000, 16'h0000, 0, 1, 0, 0, 16'h0108, 4'd1};
        vecs[5]  = '{0, 4'h0, 0, 0, 0, 0, 1, 0, 3'd3, 9'h001, 16'hFFFE, 16'h0000, 0, 1, 0, 1, 16'h0000, 4'd2};
        vecs[6]  = '{1, 4'h0, 1, 0, 1, 0, 1, 1, 3'd7, 9'h000, 16'h0000, 16'h5555, 1, 0, 1, 0, 16'h0000, 4'd2};
        vecs[7]  = '{0, 4'h0, 0, 0, 0, 0, 1, 1, 3'd6, 9'h000, 16'h0000, 16'hBEEF, 1, 0, 1, 1, 16'hBEEF, 4'd3};
        vecs[8]  = '{0, 4'h0, 0, 0, 0, 0, 0, 0, 3'd0, 9'h000, 16'h0000, 16'h0000, 1, 0, 1, 0, 16'hBEEF, 4'd3};
        vecs[9]  = '{0, 4'h0, 0, 0, 0, 0, 1, 0, 3'd7, 9'h1FF, 16'h0002, 16'h0000, 1, 0, 1, 1, 16'h0000, 4'd4};
        vecs[10] = '{0, 4'h0, 0, 0, 0, 0, 0, 0, 3'd0, 9'h000, 16'h0000, 16'h0000, 1, 0, 1, 0, 16'h0000, 4'd4};
        vecs[11] = '{0, 4'h0, 0, 0, 0, 0, 1, 1, 3'd0, 9'h000, 16'h0000, 16'h1111, 1, 0, 1, 0, 16'h0000, 4'd4};
        vecs[12] = '{0, 4'h0, 0, 0, 0, 0, 1, 1, 3'd2, 9'h000, 16'h0000, 16'h1111, 1, 0, 1, 0, 16'h0000, 4'd4};
        vecs[13] = '{0, 4'h0, 0, 0, 0, 0, 1, 1, 3'd3, 9'h000, 16'h0000, 16'h1111, 1, 0, 1, 0, 16'h0000, 4'd4};
        vecs[14] = '{0, 4'h0, 0, 1, 0, 0, 1, 1, 3'd3, 9'h000, 16'h0000, 16'h1111, 1, 0, 1, 0, 16'h0000, 4'd4};
        vecs[15] = '{1, 4'h0, 0, 1, 0, 1, 1, 1, 3'd7, 9'h000, 16'h0000, 16'h2222, 1, 0, 1, 0, 16'h0000, 4'd4};
        vecs[16] = '{1, 4'h2, 0, 1, 0, 0, 1, 1, 3'd0, 9'h000, 16'h0000, 16'h3333, 0, 0, 1, 1, 16'h3333, 4'd5};
        vecs[17] = '{0, 4'h0, 0, 0, 0, 0, 0, 0, 3'd0, 9'h000, 16'h0000, 16'h0000, 0, 0, 1, 0, 16'h3333, 4'd5};
        vecs[18] = '{0, 4'h0, 0, 0, 0, 0, 1, 1, 3'd4, 9'h000, 16'h0000, 16'h4444, 0, 0, 1, 1, 16'h4444, 4'd6};
        vecs[19] = '{0, 4'h0, 0, 0, 0, 0, 0, 0, 3'd0, 9'h000, 16'h0000, 16'h0000, 0, 0, 1, 0, 16'h4444, 4'd6};
        vecs[20] = '{0, 4'h0, 0, 0, 0, 0, 1, 1, 3'd5, 9'h000, 16'h0000, 16'h6666, 0, 0, 1, 0, 16'h4444, 4'd6};
        vecs[21] = '{1, 4'h4, 1, 0, 0, 0, 1, 1, 3'd1, 9'h000, 16'h0000, 16'h7777, 1, 0, 1, 1, 16'h7777, 4'd7};
        vecs[22] = '{0, 4'h0, 0, 0, 0, 0, 0, 0, 3'd0, 9'h000, 16'h0000, 16'h0000, 1, 0, 1, 0, 16'h7777, 4'd7};
        vecs[23] = '{1, 4'h3, 0, 1, 0, 0, 1, 1, 3'd1, 9'h000, 16'h0000, 16'h8888, 1, 0, 1, 1, 16'h8888, 4'd8};
        vecs[24] = '{0, 4'h0, 0, 0, 0, 0, 0, 0, 3'd0, 9'h000, 16'h0000, 16'h0000, 1, 0, 1, 0, 16'h8888, 4'd8};

        idle_inputs();
        rst = 1'b1;
        tick();
        tick();
        check_out("reset", 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, '0);
        rst = 1'b0;
        check_out("post_reset_no_redirect", 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, '0);

        for (int i = 0; i < 25; i++) begin
            ex_valid = vecs[i].ev; ex_opcode = vecs[i].op;
            alu_z = vecs[i].az; alu_n = vecs[i].an; alu_v = vecs[i].av;
            stall = vecs[i].st; id_branch = vecs[i].br; id_is_br = vecs[i].isbr;
            id_ccc = vecs[i].ccc; id_imm9 = vecs[i].imm;
            id_pc_plus2 = vecs[i].pc; id_rs_val = vecs[i].rs;
            tick();
            check_out($sformatf("vec%0d", i), vecs[i].fz, vecs[i].fn, vecs[i].fv,
                      vecs[i].rv, vecs[i].rpc, vecs[i].cnt);
        end

        // Taken BR held under stall, then released; flags are Z=1 N=0 V=1 here.
        for (int i = 0; i < 3; i++) begin
            br_reg(3'd7, 16'h1234, 1'b1);
            tick();
            check_out($sformatf("stall_hold%0d", i), 1'b1, 1'b0, 1'b1, 1'b0, 16'h8888, 4'd8);
        end
        br_reg(3'd7, 16'h1234, 1'b0);
        tick();
        check_out("stall_release", 1'b1, 1'b0, 1'b1, 1'b1, 16'h1234, 4'd9);
        tick();
        check_out("no_second_pulse", 1'b1, 1'b0, 1'b1, 1'b0, 16'h1234, 4'd9);
        idle_inputs();
        tick();

        // Saturation of the 4-bit counter: 9 more taken branches from 9.
        cnt_exp = 4'd9;
        for (int i = 0; i < 9; i++) begin
            br_reg(3'd7, 16'h0A00 + 16'(i), 1'b0);
            tick();
            if (cnt_exp != 4'hF) cnt_exp = cnt_exp + 4'd1;
            check_out($sformatf("sat%0d", i), 1'b1, 1'b0, 1'b1, 1'b1, 16'h0A00 + 16'(i), cnt_exp);
            idle_inputs();
            tick();
        end

        // Reset asserted while in REDIRECT.
        br_reg(3'd7, 16'hABCD, 1'b0);
        tick();
        check_out("pre_reset_redirect", 1'b1, 1'b0, 1'b1, 1'b1, 16'hABCD, 4'hF);
        rst = 1'b1;
        tick();
        check_out("reset_mid_redirect", 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, '0);
        rst = 1'b0;
        check_out("after_release", 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, '0);
        tick();
        check_out("first_after_release", 1'b0, 1'b0, 1'b0, 1'b1, 16'hABCD, 4'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
